// File: rtl/l2_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : l2_cache_pkg
// Purpose : Shared L2 cache definitions: operation codes, way/line geometry
//           and the pseudo-LRU tree helper functions.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package l2_cache_pkg;

  typedef enum logic [2:0] {
    OP_LOAD        = 3'd0,
    OP_STORE       = 3'd1,
    OP_FLUSH       = 3'd2,
    OP_DINVALIDATE = 3'd3
  } l2_op_e;

  localparam int L2_NUM_WAYS   = 4;
  localparam int L2_LINE_BYTES = 64;
  localparam int L2_ADDR_WIDTH = 26;

  // Tree bit0 picks the pair (0: ways 0/1, 1: ways 2/3); bit1 picks inside
  // ways 0/1, bit2 picks inside ways 2/3. The victim simply follows the bits.
  function automatic logic [1:0] plru_victim(input logic [2:0] tree);
    return tree[0] ? {1'b1, tree[2]} : {1'b0, tree[1]};
  endfunction

  // A touch points every bit on the path away from the used way.
  function automatic logic [2:0] plru_touch(input logic [2:0] tree,
                                            input logic [1:0] way);
    logic [2:0] r;
    r    = tree;
    r[0] = ~way[1];
    if (way[1]) r[2] = ~way[0];
    else        r[1] = ~way[0];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_cache_pseudo_lru.sv
`default_nettype none
// ============================================================================
// Module  : l2_cache_pseudo_lru
// Purpose : Per-set 3-bit tree pseudo-LRU state with combinational victim
//           read and a single touch port.
// Ports   : clk, reset (async, active-high)
//           read_set_i  -> victim_o     : victim way for the read set
//           touch_en_i, touch_set_i, touch_way_i : mark a way as recently used
// Revision: 1.0 - initial release
// ============================================================================
module l2_cache_pseudo_lru
  import l2_cache_pkg::*;
#(
  parameter int NUM_SETS = 256,
  localparam int SET_W   = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SET_W-1:0] read_set_i,
  output logic [1:0]       victim_o,
  input  logic             touch_en_i,
  input  logic [SET_W-1:0] touch_set_i,
  input  logic [1:0]       touch_way_i
);

  logic [2:0] tree_q [NUM_SETS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= 3'b000;
    end else if (touch_en_i) begin
      tree_q[touch_set_i] <= plru_touch(tree_q[touch_set_i], touch_way_i);
    end
  end

  assign victim_o = plru_victim(tree_q[read_set_i]);

endmodule
`default_nettype wire

// File: rtl/l2_cache_tag.sv
`default_nettype none
// ============================================================================
// Module  : l2_cache_tag
// Purpose : L2 tag stage. Flop-based tag/valid arrays for a 4-way L2, tag
//           lookup on the arbitration-stage bundle, fill-tag install,
//           invalidate, and registered hit/hit-way/victim results together
//           with the pass-through request for the data/directory stage.
// Ports   : clk, reset (async, active-high), stall_pipeline
//           arb_*  : request/fill bundle from the arbitration stage
//           tag_*  : registered pass-through plus tag_cache_hit,
//                    tag_hit_l2_way, tag_replace_l2_way
// Options : L2_TAG_PERF_COUNTERS_EN adds perf_l2_hits / perf_l2_misses.
// Revision: 1.0 - initial release
// ============================================================================
module l2_cache_tag
  import l2_cache_pkg::*;
#(
  parameter int NUM_SETS  = 256,
  parameter int TAG_WIDTH = L2_ADDR_WIDTH - $clog2(NUM_SETS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_pipeline,
  input  logic         arb_l2req_valid,
  input  logic [1:0]   arb_l2req_core,
  input  logic [1:0]   arb_l2req_unit,
  input  logic [1:0]   arb_l2req_strand,
  input  logic [2:0]   arb_l2req_op,
  input  logic [1:0]   arb_l2req_way,
  input  logic [25:0]  arb_l2req_address,
  input  logic [511:0] arb_l2req_data,
  input  logic [63:0]  arb_l2req_mask,
  input  logic         arb_has_sm_data,
  input  logic [511:0] arb_sm_data,
  input  logic [1:0]   arb_sm_fill_l2_way,
  output logic         tag_l2req_valid,
  output logic [1:0]   tag_l2req_core,
  output logic [1:0]   tag_l2req_unit,
  output logic [1:0]   tag_l2req_strand,
  output logic [2:0]   tag_l2req_op,
  output logic [1:0]   tag_l2req_way,
  output logic [25:0]  tag_l2req_address,
  output logic [511:0] tag_l2req_data,
  output logic [63:0]  tag_l2req_mask,
  output logic         tag_has_sm_data,
  output logic [511:0] tag_sm_data,
  output logic [1:0]   tag_sm_fill_l2_way,
  output logic         tag_cache_hit,
  output logic [1:0]   tag_hit_l2_way,
  output logic [1:0]   tag_replace_l2_way
`ifdef L2_TAG_PERF_COUNTERS_EN
  ,
  output logic [31:0]  perf_l2_hits,
  output logic [31:0]  perf_l2_misses
`endif
);

  localparam int SET_W = $clog2(NUM_SETS);

  // Tag contents need no reset: a way is only ever compared when valid.
  logic [TAG_WIDTH-1:0]   tag_q   [NUM_SETS][L2_NUM_WAYS];
  logic [L2_NUM_WAYS-1:0] valid_q [NUM_SETS];

  logic [SET_W-1:0]       req_set;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [L2_NUM_WAYS-1:0] way_match;
  logic                   lookup_hit;
  logic [1:0]             lookup_way;
  logic [1:0]             victim_way;
  logic                   accept;
  logic                   fill_we;
  logic                   inval_we;
  logic                   touch_en;
  logic [1:0]             touch_way;

  assign req_set = arb_l2req_address[SET_W-1:0];
  assign req_tag = arb_l2req_address[L2_ADDR_WIDTH-1:SET_W];

  // Lookup against the current array state; a multi-way match is illegal,
  // and the descending scan makes the lowest matching way win if it happens.
  always_comb begin
    lookup_way = 2'd0;
    for (int w = 0; w < L2_NUM_WAYS; w++)
      way_match[w] = valid_q[req_set][w] && (tag_q[req_set][w] == req_tag);
    for (int w = L2_NUM_WAYS - 1; w >= 0; w--)
      if (way_match[w]) lookup_way = w[1:0];
  end

  assign lookup_hit = |way_match;

  assign accept    = arb_l2req_valid && !stall_pipeline;
  assign fill_we   = accept && arb_has_sm_data;
  assign inval_we  = accept && !arb_has_sm_data && lookup_hit &&
                     (arb_l2req_op == 3'(OP_DINVALIDATE));
  // Invalidates leave the LRU alone; fills and ordinary hits touch it.
  assign touch_en  = fill_we ||
                     (accept && !arb_has_sm_data && lookup_hit && !inval_we);
  assign touch_way = arb_has_sm_data ? arb_sm_fill_l2_way : lookup_way;

  l2_cache_pseudo_lru #(
    .NUM_SETS (NUM_SETS)
  ) u_plru (
    .clk         (clk),
    .reset       (reset),
    .read_set_i  (req_set),
    .victim_o    (victim_way),
    .touch_en_i  (touch_en),
    .touch_set_i (req_set),
    .touch_way_i (touch_way)
  );

  always_ff @(posedge clk) begin
    if (fill_we) tag_q[req_set][arb_sm_fill_l2_way] <= req_tag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else if (fill_we) begin
      valid_q[req_set][arb_sm_fill_l2_way] <= 1'b1;
    end else if (inval_we) begin
      valid_q[req_set][lookup_way] <= 1'b0;
    end
  end

  // Stage output registers; a stall freezes all of them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_l2req_valid    <= 1'b0;
      tag_l2req_core     <= '0;
      tag_l2req_unit     <= '0;
      tag_l2req_strand   <= '0;
      tag_l2req_op       <= '0;
      tag_l2req_way      <= '0;
      tag_l2req_address  <= '0;
      tag_l2req_data     <= '0;
      tag_l2req_mask     <= '0;
      tag_has_sm_data    <= 1'b0;
      tag_sm_data        <= '0;
      tag_sm_fill_l2_way <= '0;
      tag_cache_hit      <= 1'b0;
      tag_hit_l2_way     <= '0;
      tag_replace_l2_way <= '0;
    end else if (!stall_pipeline) begin
      tag_l2req_valid    <= arb_l2req_valid;
      tag_l2req_core     <= arb_l2req_core;
      tag_l2req_unit     <= arb_l2req_unit;
      tag_l2req_strand   <= arb_l2req_strand;
      tag_l2req_op       <= arb_l2req_op;
      tag_l2req_way      <= arb_l2req_way;
      tag_l2req_address  <= arb_l2req_address;
      tag_l2req_data     <= arb_l2req_data;
      tag_l2req_mask     <= arb_l2req_mask;
      tag_has_sm_data    <= arb_has_sm_data;
      tag_sm_data        <= arb_sm_data;
      tag_sm_fill_l2_way <= arb_sm_fill_l2_way;
      // A fill reports itself as a hit in the way it is installing into.
      tag_cache_hit      <= arb_l2req_valid && (arb_has_sm_data || lookup_hit);
      tag_hit_l2_way     <= arb_has_sm_data ? arb_sm_fill_l2_way
                                            : (lookup_hit ? lookup_way : 2'd0);
      tag_replace_l2_way <= victim_way;
    end
  end

`ifdef L2_TAG_PERF_COUNTERS_EN
  logic [31:0] perf_hits_q;
  logic [31:0] perf_misses_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_hits_q   <= '0;
      perf_misses_q <= '0;
    end else if (accept && !arb_has_sm_data) begin
      if (lookup_hit) perf_hits_q   <= perf_hits_q + 32'd1;
      else            perf_misses_q <= perf_misses_q + 32'd1;
    end
  end

  assign perf_l2_hits   = perf_hits_q;
  assign perf_l2_misses = perf_misses_q;
`endif

  a_single_way_match : assert property (
    @(posedge clk) disable iff (reset)
    (arb_l2req_valid && !stall_pipeline) |-> $onehot0(way_match)
  );

endmodule
`default_nettype wire

// File: tb/tb_l2_cache_tag.sv
`default_nettype none
// ============================================================================
// Module  : tb_l2_cache_tag
// Purpose : Self-checking bench for l2_cache_tag: directed scenarios followed
//           by randomized traffic, checked against a set/way reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_l2_cache_tag;
  import l2_cache_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         stall_pipeline = 1'b0;
  logic         arb_l2req_valid = 1'b0;
  logic [1:0]   arb_l2req_core = '0, arb_l2req_unit = '0, arb_l2req_strand = '0;
  logic [2:0]   arb_l2req_op = '0;
  logic [1:0]   arb_l2req_way = '0;
  logic [25:0]  arb_l2req_address = '0;
  logic [511:0] arb_l2req_data = '0;
  logic [63:0]  arb_l2req_mask = '0;
  logic         arb_has_sm_data = 1'b0;
  logic [511:0] arb_sm_data = '0;
  logic [1:0]   arb_sm_fill_l2_way = '0;

  logic         tag_l2req_valid;
  logic [1:0]   tag_l2req_core, tag_l2req_unit, tag_l2req_strand;
  logic [2:0]   tag_l2req_op;
  logic [1:0]   tag_l2req_way;
  logic [25:0]  tag_l2req_address;
  logic [511:0] tag_l2req_data;
  logic [63:0]  tag_l2req_mask;
  logic         tag_has_sm_data;
  logic [511:0] tag_sm_data;
  logic [1:0]   tag_sm_fill_l2_way;
  logic         tag_cache_hit;
  logic [1:0]   tag_hit_l2_way;
  logic [1:0]   tag_replace_l2_way;
`ifdef L2_TAG_PERF_COUNTERS_EN
  logic [31:0]  perf_l2_hits, perf_l2_misses;
`endif

  l2_cache_tag dut (
    .clk                (clk),
    .reset              (reset),
    .stall_pipeline     (stall_pipeline),
    .arb_l2req_valid    (arb_l2req_valid),
    .arb_l2req_core     (arb_l2req_core),
    .arb_l2req_unit     (arb_l2req_unit),
    .arb_l2req_strand   (arb_l2req_strand),
    .arb_l2req_op       (arb_l2req_op),
    .arb_l2req_way      (arb_l2req_way),
    .arb_l2req_address  (arb_l2req_address),
    .arb_l2req_data     (arb_l2req_data),
    .arb_l2req_mask     (arb_l2req_mask),
    .arb_has_sm_data    (arb_has_sm_data),
    .arb_sm_data        (arb_sm_data),
    .arb_sm_fill_l2_way (arb_sm_fill_l2_way),
    .tag_l2req_valid    (tag_l2req_valid),
    .tag_l2req_core     (tag_l2req_core),
    .tag_l2req_unit     (tag_l2req_unit),
    .tag_l2req_strand   (tag_l2req_strand),
    .tag_l2req_op       (tag_l2req_op),
    .tag_l2req_way      (tag_l2req_way),
    .tag_l2req_address  (tag_l2req_address),
    .tag_l2req_data     (tag_l2req_data),
    .tag_l2req_mask     (tag_l2req_mask),
    .tag_has_sm_data    (tag_has_sm_data),
    .tag_sm_data        (tag_sm_data),
    .tag_sm_fill_l2_way (tag_sm_fill_l2_way),
    .tag_cache_hit      (tag_cache_hit),
    .tag_hit_l2_way     (tag_hit_l2_way),
    .tag_replace_l2_way (tag_replace_l2_way)
`ifdef L2_TAG_PERF_COUNTERS_EN
    ,
    .perf_l2_hits       (perf_l2_hits),
    .perf_l2_misses     (perf_l2_misses)
`endif
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: residency per set/way and LRU "which side to evict"
  // decisions kept as plain per-set flags.
  bit          m_valid [256][4];
  logic [17:0] m_tag   [256][4];
  bit          m_pair_hi [256];  // evict from ways 2/3 next
  bit          m_lo_w1   [256];  // within 0/1, evict way 1 next
  bit          m_hi_w3   [256];  // within 2/3, evict way 3 next
  int          m_hits, m_misses;

  // Expected registered outputs.
  logic         e_valid, e_hit, e_has;
  logic [1:0]   e_hitway, e_repl, e_core, e_unit, e_strand, e_way, e_fway;
  logic [2:0]   e_op;
  logic [25:0]  e_addr;
  logic [511:0] e_data, e_smdata;
  logic [63:0]  e_mask;

  task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < 256; s++) begin
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
      m_pair_hi[s] = 1'b0; m_lo_w1[s] = 1'b0; m_hi_w3[s] = 1'b0;
    end
    m_hits = 0; m_misses = 0;
    e_valid = 0; e_hit = 0; e_has = 0; e_hitway = 0; e_repl = 0; e_core = 0;
    e_unit = 0; e_strand = 0; e_way = 0; e_fway = 0; e_op = 0; e_addr = 0;
    e_data = 0; e_smdata = 0; e_mask = 0;
  endfunction

  // Using a way steers the next eviction to the other side of each decision.
  function automatic void model_use(input int s, input int w);
    m_pair_hi[s] = (w < 2);
    if (w < 2) m_lo_w1[s] = (w == 0);
    else       m_hi_w3[s] = (w == 2);
  endfunction

  function automatic int model_victim(input int s);
    if (m_pair_hi[s]) return m_hi_w3[s] ? 3 : 2;
    return m_lo_w1[s] ? 1 : 0;
  endfunction

  task automatic check_outputs();
    chk("valid", tag_l2req_valid, e_valid);
    chk("hit", tag_cache_hit, e_hit);
    if (e_valid) begin
      chk("hit_way", tag_hit_l2_way, e_hitway);
      chk("replace_way", tag_replace_l2_way, e_repl);
      chk("op", tag_l2req_op, e_op);
      chk("address", tag_l2req_address, e_addr);
      chk("data", tag_l2req_data, e_data);
      chk("mask", tag_l2req_mask, e_mask);
      chk("id", {tag_l2req_core, tag_l2req_unit, tag_l2req_strand, tag_l2req_way},
          {e_core, e_unit, e_strand, e_way});
      chk("has_sm_data", tag_has_sm_data, e_has);
      chk("sm_data", tag_sm_data, e_smdata);
      chk("fill_way", tag_sm_fill_l2_way, e_fway);
    end
`ifdef L2_TAG_PERF_COUNTERS_EN
    chk("perf_hits", perf_l2_hits, m_hits);
    chk("perf_misses", perf_l2_misses, m_misses);
`endif
  endtask

  // One pipeline cycle: drive, predict, clock, check.
  task automatic step(input bit v, input logic [2:0] op, input logic [25:0] addr,
                      input bit fill, input logic [1:0] fway, input bit stl);
    int s, t, hw, vic;
    bit hit;
    logic [511:0] d, sd;
    for (int i = 0; i < 16; i++) begin
      d[i*32 +: 32]  = $urandom();
      sd[i*32 +: 32] = $urandom();
    end
    arb_l2req_valid    = v;
    arb_l2req_op       = op;
    arb_l2req_address  = addr;
    arb_has_sm_data    = fill;
    arb_sm_fill_l2_way = fway;
    stall_pipeline     = stl;
    arb_l2req_data     = d;
    arb_sm_data        = sd;
    arb_l2req_mask     = {$urandom(), $urandom()};
    arb_l2req_core     = 2'($urandom());
    arb_l2req_unit     = 2'($urandom());
    arb_l2req_strand   = 2'($urandom());
    arb_l2req_way      = 2'($urandom());

    s = int'(addr[7:0]);
    t = int'(addr[25:8]);
    hit = 0; hw = 0;
    for (int w = 3; w >= 0; w--)
      if (m_valid[s][w] && m_tag[s][w] == 18'(t)) begin hit = 1; hw = w; end
    vic = model_victim(s);

    if (!stl) begin
      e_valid = v;
      e_hit   = v && (fill || hit);
      if (v) begin
        e_hitway = fill ? fway : 2'(hw);
        e_repl = 2'(vic); e_op = op; e_addr = addr; e_data = d; e_smdata = sd;
        e_mask = arb_l2req_mask; e_has = fill; e_fway = fway;
        e_core = arb_l2req_core; e_unit = arb_l2req_unit;
        e_strand = arb_l2req_strand; e_way = arb_l2req_way;
        if (fill) begin
          m_tag[s][fway] = 18'(t);
          m_valid[s][fway] = 1'b1;
          model_use(s, int'(fway));
        end else begin
          if (hit) m_hits++; else m_misses++;
          if (hit && op == 3'(OP_DINVALIDATE)) m_valid[s][hw] = 1'b0;
          else if (hit) model_use(s, hw);
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", tag_l2req_valid, 0);
    chk("rst_hit", tag_cache_hit, 0);
    chk("rst_ways", {tag_hit_l2_way, tag_replace_l2_way, tag_sm_fill_l2_way}, 0);
    chk("rst_addr", tag_l2req_address, 0);
    chk("rst_data", tag_l2req_data, 0);
    chk("rst_sm_data", tag_sm_data, 0);
    chk("rst_misc", {tag_l2req_core, tag_l2req_unit, tag_l2req_strand, tag_l2req_op,
                     tag_l2req_way, tag_l2req_mask, tag_has_sm_data}, 0);
`ifdef L2_TAG_PERF_COUNTERS_EN
    chk("rst_perf", {perf_l2_hits, perf_l2_misses}, 0);
`endif
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  localparam logic [2:0] LD = 3'(OP_LOAD);
  localparam logic [2:0] DI = 3'(OP_DINVALIDATE);

  initial begin : main
    logic [7:0] sets [4];
    int s, t, fw;
    bit fill, v, stl;
    logic [2:0] op;
    sets[0] = 8'h05; sets[1] = 8'h23; sets[2] = 8'h7f; sets[3] = 8'h00;

    model_clear();
    @(posedge clk); #1;
    do_reset();

    // First lookup after reset: miss, victim way 0.
    step(1, LD, 26'h0000123, 0, 0, 0);
    chk("first_hit", tag_cache_hit, 0);
    chk("first_victim", tag_replace_l2_way, 0);
    chk("first_valid", tag_l2req_valid, 1);

    // Fill way 2 then hit it; same set with another tag misses.
    step(1, LD, 26'h0000123, 1, 2, 0);
    step(1, LD, 26'h0000123, 0, 0, 0);
    chk("fill_hit", {tag_cache_hit, tag_hit_l2_way}, {1'b1, 2'd2});
    step(1, LD, 26'h0000223, 0, 0, 0);
    chk("other_tag_miss", tag_cache_hit, 0);

    // Fill all four ways of set 0x05 in order.
    for (int w = 0; w < 4; w++) step(1, LD, {18'(w + 1), 8'h05}, 1, 2'(w), 0);
    step(1, LD, 26'h0000505, 0, 0, 0);
    chk("plru_after_fills", tag_replace_l2_way, 0);
    step(1, LD, 26'h0000105, 0, 0, 0);
    step(1, LD, 26'h0000505, 0, 0, 0);
    chk("plru_after_hit0", tag_replace_l2_way, 2);

    // Invalidate way 1 of set 0x05; the other ways stay resident.
    step(1, DI, 26'h0000205, 0, 0, 0);
    step(1, LD, 26'h0000205, 0, 0, 0);
    chk("dinv_miss", tag_cache_hit, 0);
    step(1, LD, 26'h0000105, 0, 0, 0);
    step(1, LD, 26'h0000305, 0, 0, 0);
    step(1, LD, 26'h0000405, 0, 0, 0);
    chk("dinv_others_hit", {tag_cache_hit, tag_hit_l2_way}, {1'b1, 2'd3});

    // Stalled fill is ignored and outputs stay frozen.
    for (int i = 0; i < 3; i++) step(1, LD, 26'h0000777, 1, 1, 1);
    chk("stall_frozen_addr", tag_l2req_address, 26'h0000405);
    step(1, LD, 26'h0000777, 0, 0, 0);
    chk("stall_no_install", tag_cache_hit, 0);
    step(1, LD, 26'h0000777, 1, 1, 0);
    step(1, LD, 26'h0000777, 0, 0, 0);
    chk("unstall_install", {tag_cache_hit, tag_hit_l2_way}, {1'b1, 2'd1});

    // Reset mid-stream after four fills; every lookup then misses.
    for (int w = 0; w < 4; w++) step(1, LD, {18'(w + 9), 8'h42}, 1, 2'(w), 0);
    do_reset();
    for (int w = 0; w < 4; w++) begin
      step(1, LD, {18'(w + 9), 8'h42}, 0, 0, 0);
      chk("post_reset_miss", tag_cache_hit, 0);
    end

    // Randomized traffic over a few sets and tags to force reuse.
    for (int n = 0; n < 400; n++) begin
      v    = ($urandom_range(0, 9) != 0);
      stl  = ($urandom_range(0, 7) == 0);
      fill = ($urandom_range(0, 3) == 0);
      op   = 3'($urandom_range(0, 3));
      s    = int'(sets[$urandom_range(0, 3)]);
      t    = $urandom_range(1, 6);
      fw   = $urandom_range(0, 3);
      // Never install a tag in a second way of the same set.
      for (int w = 0; w < 4; w++)
        if (m_valid[s][w] && m_tag[s][w] == 18'(t)) fw = w;
      step(v, op, {18'(t), 8'(s)}, fill, 2'(fw), stl);
    end

    stall_pipeline = 1'b0;
    arb_l2req_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
